mu2cgra_stream_adapter: RTL and testbench

MU2CGRA_STREAM_ADAPTER -- requirements
Module: mu2cgra_stream_adapter

---
 rtl/mu2cgra_stream_adapter.sv | 103 ++++++++++
 tb/tb_mu2cgra_stream_adapter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mu2cgra_stream_adapter.sv
// Buffers fused matrix-unit words in a small FIFO and replays each head word to the CGRA
// as BEATS narrower beats, lowest lanes first; the word pops on its last beat.
module mu2cgra_stream_adapter #(
   parameter  int unsigned NUM_LANES  = 32,
   parameter  int unsigned LANE_W     = 16,
   parameter  int unsigned OUT_LANES  = 32,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned BEATS      = NUM_LANES / OUT_LANES,
   localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1),
   localparam int unsigned IN_W       = NUM_LANES * LANE_W,
   localparam int unsigned OUT_W      = OUT_LANES * LANE_W
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [IN_W-1:0]   in_dat,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [OUT_W-1:0]  out_dat,
   output logic              out_last,
   output logic [BEAT_W-1:0] out_beat,
   output logic [OCC_W-1:0]  occupancy,
   output logic [31:0]       word_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [OCC_W-1:0]  FULL_OCC  = OCC_W'(FIFO_DEPTH);

   if (NUM_LANES % OUT_LANES != 0) begin : gen_bad_lanes
      $error("NUM_LANES must be a multiple of OUT_LANES");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end

   logic [IN_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [31:0]       word_cnt_q, word_cnt_d;

   logic [BEATS-1:0][OUT_W-1:0] head_beats;
   logic push, fire, pop;

   // Both handshakes are gated by reset so nothing moves while reset_in is low.
   assign in_rdy   = reset_in && (occ_q != FULL_OCC);
   assign out_vld  = reset_in && (occ_q != '0);
   assign out_last = out_vld && (beat_q == LAST_BEAT);
   assign push     = in_vld && in_rdy;
   assign fire     = out_vld && out_rdy;
   assign pop      = fire && out_last;

   assign head_beats = mem_q[rd_ptr_q];
   assign out_dat    = out_vld ? head_beats[beat_q] : '0;
   assign out_beat   = beat_q;
   assign occupancy  = occ_q;
   assign word_cnt   = word_cnt_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      beat_d     = beat_q;
      word_cnt_d = word_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         word_cnt_d = word_cnt_q + 32'd1;
      end
      if (fire) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         beat_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         beat_q     <= beat_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   // Storage needs no reset: out_dat is zeroed whenever the FIFO is empty.
   always_ff @(posedge clk_in) begin
      if (push) mem_q[wr_ptr_q] <= in_dat;
   end

endmodule

// File: tb/tb_mu2cgra_stream_adapter.sv
// Directed bench: a 4-beat adapter (OUT_LANES=8) and a single-beat adapter (OUT_LANES=32)
// driven with hand-built words whose lane i holds base+i.
module tb_mu2cgra_stream_adapter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 4-beat instance
   logic         in_vld, in_rdy, out_vld, out_rdy, out_last;
   logic [511:0] in_dat;
   logic [127:0] out_dat;
   logic [1:0]   out_beat;
   logic [2:0]   occupancy;
   logic [31:0]  word_cnt;

   // single-beat instance
   logic         b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_out_last;
   logic [511:0] b_in_dat, b_out_dat;
   logic [0:0]   b_out_beat;
   logic [2:0]   b_occupancy;
   logic [31:0]  b_word_cnt;

   int nvec = 0;
   int nerr = 0;

   mu2cgra_stream_adapter #(.NUM_LANES(32), .LANE_W(16), .OUT_LANES(8), .FIFO_DEPTH(4)) dut (
      .clk_in(clk), .reset_in(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_last(out_last),
      .out_beat(out_beat), .occupancy(occupancy), .word_cnt(word_cnt)
   );

   mu2cgra_stream_adapter #(.NUM_LANES(32), .LANE_W(16), .OUT_LANES(32), .FIFO_DEPTH(4)) dut1 (
      .clk_in(clk), .reset_in(rst_n), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_dat(b_in_dat),
      .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_dat(b_out_dat), .out_last(b_out_last),
      .out_beat(b_out_beat), .occupancy(b_occupancy), .word_cnt(b_word_cnt)
   );

   function automatic logic [511:0] mkword(input int base);
      logic [511:0] w;
      for (int i = 0; i < 32; i++) w[i*16 +: 16] = 16'(base + i);
      return w;
   endfunction

   function automatic logic [127:0] mkbeat(input int base, input int k);
      logic [127:0] b;
      for (int j = 0; j < 8; j++) b[j*16 +: 16] = 16'(base + 8*k + j);
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_vld = 1'b1; in_dat = mkword(7); out_rdy = 1'b1;
      b_in_vld = 1'b0; b_in_dat = '0; b_out_rdy = 1'b0;
      tick(); tick();
      nvec++; if (in_rdy !== 1'b0) begin nerr++; $display("FAIL rst_in_rdy got %0b want 0", in_rdy); end
      nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL rst_out_vld got %0b want 0", out_vld); end
      nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL rst_out_last got %0b want 0", out_last); end
      nvec++; if (out_dat !== '0) begin nerr++; $display("FAIL rst_out_dat got %0h want 0", out_dat); end
      nvec++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL rst_occ got %0d want 0", occupancy); end
      nvec++; if (word_cnt !== 32'd0) begin nerr++; $display("FAIL rst_word_cnt got %0d want 0", word_cnt); end
      rst_n = 1'b1; in_vld = 1'b0;
      #1;
      nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL rst_release_in_rdy got %0b want 1", in_rdy); end
      tick();
   endtask

   task automatic test_single_word();
      out_rdy = 1'b1; in_vld = 1'b1; in_dat = mkword(0);
      #1;
      nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL single_same_cycle out_vld got %0b want 0", out_vld); end
      tick();
      in_vld = 1'b0;
      for (int k = 0; k < 4; k++) begin
         nvec++; if (out_vld !== 1'b1) begin nerr++; $display("FAIL single_vld beat %0d got %0b want 1", k, out_vld); end
         nvec++; if (out_beat !== 2'(k)) begin nerr++; $display("FAIL single_beat got %0d want %0d", out_beat, k); end
         nvec++; if (out_dat !== mkbeat(0, k)) begin nerr++; $display("FAIL single_dat beat %0d got %0h want %0h", k, out_dat, mkbeat(0, k)); end
         nvec++; if (out_last !== (k == 3)) begin nerr++; $display("FAIL single_last beat %0d got %0b want %0b", k, out_last, (k == 3)); end
         tick();
      end
      nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL single_after out_vld got %0b want 0", out_vld); end
      nvec++; if (word_cnt !== 32'd1) begin nerr++; $display("FAIL single_word_cnt got %0d want 1", word_cnt); end
   endtask

   task automatic test_fill_full();
      int bases[5] = '{100, 200, 300, 400, 500};
      out_rdy = 1'b0;
      for (int w = 0; w < 5; w++) begin
         in_vld = 1'b1; in_dat = mkword(bases[w]);
         #1;
         nvec++; if (in_rdy !== (w < 4)) begin nerr++; $display("FAIL fill_in_rdy word %0d got %0b want %0b", w, in_rdy, (w < 4)); end
         if (w < 4) tick();
      end
      nvec++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL fill_occ got %0d want 4", occupancy); end
      out_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         nvec++; if (in_rdy !== 1'b0) begin nerr++; $display("FAIL full_no_bypass beat %0d got %0b want 0", k, in_rdy); end
         nvec++; if (out_dat !== mkbeat(100, k)) begin nerr++; $display("FAIL full_dat beat %0d got %0h want %0h", k, out_dat, mkbeat(100, k)); end
         tick();
      end
      nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL after_pop_in_rdy got %0b want 1", in_rdy); end
      nvec++; if (occupancy !== 3'd3) begin nerr++; $display("FAIL after_pop_occ got %0d want 3", occupancy); end
      out_rdy = 1'b0;
      tick();
      in_vld = 1'b0;
      nvec++; if (occupancy !== 3'd4) begin nerr++; $display("FAIL held_push_occ got %0d want 4", occupancy); end
      out_rdy = 1'b1;
      for (int w = 1; w < 5; w++) begin
         for (int k = 0; k < 4; k++) begin
            nvec++;
            if (out_dat !== mkbeat(bases[w], k)) begin
               nerr++; $display("FAIL drain_dat word %0d beat %0d got %0h want %0h", w, k, out_dat, mkbeat(bases[w], k));
            end
            tick();
         end
      end
      nvec++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL drain_occ got %0d want 0", occupancy); end
      nvec++; if (word_cnt !== 32'd6) begin nerr++; $display("FAIL drain_word_cnt got %0d want 6", word_cnt); end
   endtask

   task automatic test_backpressure();
      int k = 0;
      out_rdy = 1'b0; in_vld = 1'b1; in_dat = mkword(1000);
      tick();
      in_vld = 1'b0;
      for (int c = 0; c < 20 && k < 4; c++) begin
         nvec++; if (out_beat !== 2'(k)) begin nerr++; $display("FAIL bp_beat cyc %0d got %0d want %0d", c, out_beat, k); end
         nvec++; if (out_dat !== mkbeat(1000, k)) begin nerr++; $display("FAIL bp_dat cyc %0d got %0h want %0h", c, out_dat, mkbeat(1000, k)); end
         nvec++; if (out_last !== (k == 3)) begin nerr++; $display("FAIL bp_last cyc %0d got %0b want %0b", c, out_last, (k == 3)); end
         out_rdy = c[0];
         tick();
         if (out_rdy) k++;
      end
      out_rdy = 1'b0;
      nvec++; if (k != 4) begin nerr++; $display("FAIL bp_timeout beats got %0d want 4", k); end
      nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL bp_done out_vld got %0b want 0", out_vld); end
      nvec++; if (word_cnt !== 32'd7) begin nerr++; $display("FAIL bp_word_cnt got %0d want 7", word_cnt); end
   endtask

   task automatic test_reset_mid_word();
      int bases[3] = '{2000, 3000, 4000};
      out_rdy = 1'b0;
      for (int w = 0; w < 3; w++) begin
         in_vld = 1'b1; in_dat = mkword(bases[w]);
         tick();
      end
      in_vld = 1'b0; out_rdy = 1'b1;
      tick(); tick();
      nvec++; if (out_beat !== 2'd2) begin nerr++; $display("FAIL mid_beat got %0d want 2", out_beat); end
      rst_n = 1'b0; in_vld = 1'b1; in_dat = mkword(9000);
      #1;
      nvec++; if (out_vld !== 1'b0) begin nerr++; $display("FAIL mid_rst_out_vld got %0b want 0", out_vld); end
      nvec++; if (in_rdy !== 1'b0) begin nerr++; $display("FAIL mid_rst_in_rdy got %0b want 0", in_rdy); end
      tick();
      nvec++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL mid_rst_occ got %0d want 0", occupancy); end
      nvec++; if (word_cnt !== 32'd0) begin nerr++; $display("FAIL mid_rst_word_cnt got %0d want 0", word_cnt); end
      nvec++; if (out_beat !== 2'd0) begin nerr++; $display("FAIL mid_rst_beat got %0d want 0", out_beat); end
      rst_n = 1'b1; in_dat = mkword(5000);
      #1;
      nvec++; if (in_rdy !== 1'b1) begin nerr++; $display("FAIL mid_release_in_rdy got %0b want 1", in_rdy); end
      tick();
      in_vld = 1'b0;
      nvec++; if (out_vld !== 1'b1) begin nerr++; $display("FAIL mid_new_vld got %0b want 1", out_vld); end
      nvec++; if (out_beat !== 2'd0) begin nerr++; $display("FAIL mid_new_beat got %0d want 0", out_beat); end
      nvec++; if (out_dat !== mkbeat(5000, 0)) begin nerr++; $display("FAIL mid_new_dat got %0h want %0h", out_dat, mkbeat(5000, 0)); end
      for (int k = 0; k < 4; k++) tick();
      nvec++; if (word_cnt !== 32'd1) begin nerr++; $display("FAIL mid_new_word_cnt got %0d want 1", word_cnt); end
      nvec++; if (occupancy !== 3'd0) begin nerr++; $display("FAIL mid_new_occ got %0d want 0", occupancy); end
   endtask

   task automatic test_word_cnt_wrap();
      out_rdy = 1'b1;
      force dut.word_cnt_q = 32'hFFFF_FFFF;
      tick();
      release dut.word_cnt_q;
      #1;
      nvec++; if (word_cnt !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL wrap_preload got %0h want ffffffff", word_cnt); end
      in_vld = 1'b1; in_dat = mkword(6000);
      tick();
      in_vld = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      nvec++; if (word_cnt !== 32'd0) begin nerr++; $display("FAIL wrap_word_cnt got %0h want 0", word_cnt); end
   endtask

   task automatic test_back_to_back_single_beat();
      b_out_rdy = 1'b0;
      for (int w = 0; w < 2; w++) begin
         b_in_vld = 1'b1; b_in_dat = mkword(10 * (w + 1));
         tick();
      end
      b_out_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b_in_dat = mkword(10 * (i + 3));
         #1;
         nvec++; if (b_occupancy !== 3'd2) begin nerr++; $display("FAIL b2b_occ cyc %0d got %0d want 2", i, b_occupancy); end
         nvec++; if (b_in_rdy !== 1'b1) begin nerr++; $display("FAIL b2b_in_rdy cyc %0d got %0b want 1", i, b_in_rdy); end
         nvec++; if (b_out_last !== 1'b1 || b_out_vld !== 1'b1) begin
            nerr++; $display("FAIL b2b_last cyc %0d got vld %0b last %0b want 1 1", i, b_out_vld, b_out_last);
         end
         nvec++; if (b_out_dat !== mkword(10 * (i + 1))) begin
            nerr++; $display("FAIL b2b_dat cyc %0d got %0h want %0h", i, b_out_dat, mkword(10 * (i + 1)));
         end
         tick();
      end
      b_in_vld = 1'b0;
      tick(); tick();
      nvec++; if (b_occupancy !== 3'd0) begin nerr++; $display("FAIL b2b_drain_occ got %0d want 0", b_occupancy); end
      nvec++; if (b_out_last !== 1'b0) begin nerr++; $display("FAIL b2b_idle_last got %0b want 0", b_out_last); end
      nvec++; if (b_word_cnt !== 32'd8) begin nerr++; $display("FAIL b2b_word_cnt got %0d want 8", b_word_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_fill_full();
      test_backpressure();
      test_reset_mid_word();
      test_word_cnt_wrap();
      test_back_to_back_single_beat();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
